// File: rtl/fft_sdf_bf.sv
// rtl/fft_sdf_bf.sv - radix-2 DIF single-delay-feedback butterfly stage
// Pairs samples D apart through a feedback delay line and emits scaled sum/difference.
module fft_sdf_bf #(
   parameter int WIDTH = 24,
   parameter int N     = 1024,
   parameter int STAGE = 0
) (
   input  logic                          clk,
   input  logic                          srst_n,
   input  logic                          carry_in,
   output logic                          carry_out,
   input  logic [$clog2(N)-1:0]          ctr_i,
   output logic [$clog2(N)-1:0]          ctr_o,
   input  logic signed [WIDTH-1:0]       x_re_i,
   input  logic signed [WIDTH-1:0]       x_im_i,
   output logic signed [WIDTH-1:0]       z_re_o,
   output logic signed [WIDTH-1:0]       z_im_o
);

   localparam int LOGN = $clog2(N);
   localparam int D    = N >> (STAGE + 1);
   localparam int DW   = LOGN + 2 * WIDTH;

   // Halve with round-half-to-even, then clamp to the WIDTH-bit range.
   function automatic logic signed [WIDTH-1:0] scale(input logic signed [WIDTH:0] v);
      logic signed [WIDTH:0] q;
      q = v >>> 1;
      if (v[0] && q[0])
         q = q + {{WIDTH{1'b0}}, 1'b1};
      if (q[WIDTH] != q[WIDTH-1])
         scale = q[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else
         scale = q[WIDTH-1:0];
   endfunction

   logic                    b;
   logic [DW-1:0]           dl_in;
   logic [DW-1:0]           dl_out;
   logic [LOGN-1:0]         d_ctr;
   logic signed [WIDTH-1:0] d_re;
   logic signed [WIDTH-1:0] d_im;
   logic signed [WIDTH:0]   s_re;
   logic signed [WIDTH:0]   s_im;
   logic signed [WIDTH:0]   t_re;
   logic signed [WIDTH:0]   t_im;
   logic [D:0]              carry_sr;

   assign b = ctr_i[LOGN-1-STAGE];
   assign {d_ctr, d_re, d_im} = dl_out;

   assign s_re = {d_re[WIDTH-1], d_re} + {x_re_i[WIDTH-1], x_re_i};
   assign s_im = {d_im[WIDTH-1], d_im} + {x_im_i[WIDTH-1], x_im_i};
   assign t_re = {d_re[WIDTH-1], d_re} - {x_re_i[WIDTH-1], x_re_i};
   assign t_im = {d_im[WIDTH-1], d_im} - {x_im_i[WIDTH-1], x_im_i};

   // The sample index rides in the delay line so ctr_o stays aligned with z.
   assign dl_in = b ? {ctr_i, scale(t_re), scale(t_im)} : {ctr_i, x_re_i, x_im_i};

   generate
      if (D < 16) begin : g_shift
         logic [DW-1:0] sr [D];
         always_ff @(posedge clk) begin
            sr[0] <= dl_in;
            for (int i = 1; i < D; i++)
               sr[i] <= sr[i-1];
         end
         assign dl_out = sr[D-1];
      end else begin : g_ram
         localparam int AW = $clog2(D);
         logic [DW-1:0] mem [D];
         // Read-before-write on the same slot returns the entry from D cycles ago.
         always_ff @(posedge clk)
            mem[ctr_i[AW-1:0]] <= dl_in;
         assign dl_out = mem[ctr_i[AW-1:0]];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!srst_n)
         carry_sr <= '0;
      else
         carry_sr <= {carry_sr[D-1:0], carry_in};
   end

   assign carry_out = carry_sr[D];

   always_ff @(posedge clk)
      ctr_o <= d_ctr;

   always_ff @(posedge clk) begin
      if (!srst_n) begin
         z_re_o <= '0;
         z_im_o <= '0;
      end else if (b) begin
         z_re_o <= scale(s_re);
         z_im_o <= scale(s_im);
      end else begin
         z_re_o <= d_re;
         z_im_o <= d_im;
      end
   end

endmodule
